fifo_rd_deframer: RTL and testbench
===================================

# fifo_rd_deframer

Read-side consumer of the async FIFO, clocked in the FIFO read domain. It drains FIFO words through the `empty`/`rd`/`dataout` interface and absorbs the FIFO's one-cycle read latency in a 3-entry output buffer. It checks SOP/EOP packet framing carried in the two MSBs of each word and presents payload on a valid/ready stream with per-word error marking and saturating packet and error counters.

## Interface

Parameters:
- `WIDTH`, default 18: FIFO word width; must be ≥ 3. Bit WIDTH-1 is SOP, bit WIDTH-2 is EOP, and bits WIDTH-3:0 are payload.
- `MAX_LEN`, default 64: maximum legal packet length in words, SOP word included; range 1..65535.

Ports:
- `rdclk` input, 1 bit: the single clock; all logic is on its rising edge.
- `reset` input, 1 bit: asynchronous, active-high. It is shared with the FIFO.
- `empty` input, 1 bit: FIFO empty flag.
- `rd` output, 1 bit: FIFO read strobe.
- `dataout` input, WIDTH bits: FIFO read data. It is valid in the cycle after a cycle with `rd`=1 and `empty`=0.
- `m_valid` output, 1 bit: the output word is valid.
- `m_ready` input, 1 bit: the consumer accepts the word. A word transfers on any edge with `m_valid`=1 and `m_ready`=1.
- `m_data` output, WIDTH-2 bits: payload.
- `m_sop` output, 1 bit: SOP flag of the word.
- `m_eop` output, 1 bit: EOP flag of the word.
- `m_err` output, 1 bit: the word violated framing.
- `pkt_count` output, 16 bits: count of well-formed packets received; saturates.
- `err_count` output, 16 bits: count of words flagged with `m_err`; saturates.

## Operation

- **Read issue:**
  - `rd = !empty && (count + rd_q) < 3`, where `count` is the buffer occupancy (0..3) and `rd_q` is a registered copy of `rd && !empty`.
  - `rd` has no combinational dependence on `m_ready`.
- **Capture:** when `rd_q`=1, `dataout` is classified and pushed into the buffer together with its sop, eop and err flags. The buffer never overflows, because the issue rule guarantees a free slot.
- **Output:** `m_*` are driven from the buffer head and are registered. `m_valid = (count != 0)`. A push and a pop in the same cycle leave `count` unchanged.
- **Framing FSM:** evaluated on each captured word. It has two states, IDLE and IN_PKT, plus `len` (16 bits).
  - IDLE, sop=1, eop=1: single-word packet, err=0; increment `pkt_count`; stay in IDLE.
  - IDLE, sop=1, eop=0: err=0; `len`=1; go to IN_PKT.
  - IDLE, sop=0: orphan word, err=1; stay in IDLE.
  - IN_PKT, sop=1: err=1. The previous packet is abandoned. The word starts a new packet with `len`=1; if its eop=1, go to IDLE without incrementing `pkt_count`.
  - IN_PKT, sop=0, `len`+1 > MAX_LEN: err=1; go to IDLE.
  - IN_PKT, sop=0, eop=1, within limit: err=0; increment `pkt_count`; go to IDLE.
  - IN_PKT, sop=0, eop=0, within limit: err=0; increment `len`.
- **Counters:** `err_count` increments once per captured word with err=1. Both counters hold at 0xFFFF once reached. Counting happens at capture time, not at transfer time.
- **Payload:** `m_data` is passed unmodified, including on errored words.

## Timing

- **Reset values:** `rd`=0, `m_valid`=0, `m_data`/`m_sop`/`m_eop`/`m_err`=0, `pkt_count`=0, `err_count`=0. Also cleared: state=IDLE, `len`=0, `count`=0, `rd_q`=0.
- **Reset mid-operation:** buffered words and in-flight reads are discarded; `rd` drops asynchronously.
- **Latency:**
  - `rd` high in cycle t → word captured at the end of t+1 → `m_valid` high in t+2.
  - When `empty` falls in cycle t with the buffer idle, the first `m_valid` appears in t+2.
- **Throughput:** with `m_ready` held at 1 and the FIFO non-empty, one word per cycle, with `rd` continuously high and `count`=1 in steady state.
- **Backpressure:**
  - With `m_ready`=0, at most 3 words are buffered, after which `rd` stays 0.
  - After `m_ready` rises, `rd` reasserts in the cycle following the first pop.
- **Stall hold:** while `m_valid`=1 and `m_ready`=0, `m_*` hold stable.
- **Counter visibility:** `pkt_count` updates one edge after capture of the EOP word.

## Test plan

- **Reset:** assert `reset` asynchronously with 2 words buffered → all outputs 0 immediately. After release with `empty`=1, `rd` stays 0.
- **Streaming:** FIFO holds packet words {SOP|0x0001, 0x0002, EOP|0x0003}, `m_ready`=1 → `rd` high for 3 consecutive cycles. `m_valid` starts 2 cycles after the first `rd`, and 3 back-to-back words come out with sop/eop 10, 00, 01. `pkt_count`=1, `err_count`=0.
- **Backpressure:** 10 single-word packets with `m_ready`=0 → exactly 3 reads, then `rd`=0 and `count`=3. Release `m_ready` → all 10 words delivered in order and `pkt_count`=10.
- **Framing errors:** send the word sequence 0x0005 (no SOP), then SOP, then SOP|EOP. The orphan word gets `m_err`=1 and the second SOP gets `m_err`=1 → `err_count`=2, `pkt_count`=0.
- **Length limit:** with MAX_LEN=4, send SOP followed by 5 non-EOP words → the 5th word of the packet is flagged. The following word is flagged as an orphan, giving `err_count`=2.
- **Saturation:** preload with 65537 orphan words, or reduce the run via a force in the bench → `err_count` holds at 0xFFFF.

Source files
------------

// File: rtl/fifo_rd_deframer.sv
// fifo_rd_deframer: read-domain FIFO drain with SOP/EOP framing check,
// 3-deep output buffer and saturating packet/error counters.
module fifo_rd_deframer #(
  parameter int WIDTH   = 18,
  parameter int MAX_LEN = 64
) (
  input  logic             rdclk,
  input  logic             reset,
  input  logic             empty,
  output logic             rd,
  input  logic [WIDTH-1:0] dataout,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-3:0] m_data,
  output logic             m_sop,
  output logic             m_eop,
  output logic             m_err,
  output logic [15:0]      pkt_count,
  output logic [15:0]      err_count
);

  localparam int PW = WIDTH - 2;
  localparam logic [16:0] MAX_L = 17'(MAX_LEN);

  typedef struct packed {
    logic          err;
    logic          sop;
    logic          eop;
    logic [PW-1:0] data;
  } ent_t;

  typedef enum logic {
    IDLE,
    IN_PKT
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [15:0] len;
  logic [15:0] len_nx;
  logic [16:0] len_p1;
  logic [1:0]  count;
  logic [1:0]  wr_idx;
  logic [2:0]  inflight;
  logic        rd_q;
  logic        push;
  logic        pop;
  logic        in_sop;
  logic        in_eop;
  logic        w_err;
  logic        pkt_inc;
  ent_t        in_e;
  ent_t        slot_q [3];

  // Reads are only issued when a buffer slot is guaranteed free.
  assign inflight = {1'b0, count} + {2'b0, rd_q};
  assign rd       = !reset && !empty && (inflight < 3'd3);

  assign push   = rd_q;
  assign pop    = m_valid && m_ready;
  assign wr_idx = count - {1'b0, pop};

  assign in_sop = dataout[WIDTH-1];
  assign in_eop = dataout[WIDTH-2];
  assign in_e   = {w_err, dataout};
  assign len_p1 = {1'b0, len} + 17'd1;

  assign m_valid = (count != 2'd0);
  assign m_data  = slot_q[0].data;
  assign m_sop   = slot_q[0].sop;
  assign m_eop   = slot_q[0].eop;
  assign m_err   = slot_q[0].err;

  always_comb begin
    state_nx = state;
    len_nx   = len;
    w_err    = 1'b0;
    pkt_inc  = 1'b0;
    if (rd_q) begin
      unique case (state)
        IDLE: begin
          if (!in_sop) begin
            w_err = 1'b1;
          end else if (in_eop) begin
            pkt_inc = 1'b1;
          end else begin
            len_nx   = 16'd1;
            state_nx = IN_PKT;
          end
        end
        IN_PKT: begin
          if (in_sop) begin
            w_err    = 1'b1;
            len_nx   = 16'd1;
            state_nx = in_eop ? IDLE : IN_PKT;
          end else if (len_p1 > MAX_L) begin
            w_err    = 1'b1;
            state_nx = IDLE;
          end else if (in_eop) begin
            pkt_inc  = 1'b1;
            state_nx = IDLE;
          end else begin
            len_nx = len_p1[15:0];
          end
        end
      endcase
    end
  end

  always_ff @(posedge rdclk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      len       <= '0;
      pkt_count <= '0;
      err_count <= '0;
    end else begin
      state <= state_nx;
      len   <= len_nx;
      if (pkt_inc && pkt_count != 16'hFFFF)
        pkt_count <= pkt_count + 16'd1;
      if (w_err && err_count != 16'hFFFF)
        err_count <= err_count + 16'd1;
    end
  end

  // Head sits in slot 0; a pop shifts down and a push lands behind it.
  always_ff @(posedge rdclk or posedge reset) begin
    if (reset) begin
      count <= '0;
      rd_q  <= 1'b0;
      for (int i = 0; i < 3; i++)
        slot_q[i] <= '0;
    end else begin
      rd_q  <= rd;
      count <= count + {1'b0, push} - {1'b0, pop};
      if (pop) begin
        slot_q[0] <= slot_q[1];
        slot_q[1] <= slot_q[2];
      end
      if (push)
        slot_q[wr_idx] <= in_e;
    end
  end

endmodule

// File: tb/tb_fifo_rd_deframer.sv
// tb_fifo_rd_deframer: directed and random stimulus against a
// queue-based FIFO model and a framing reference model.
module tb_fifo_rd_deframer;

  localparam int W  = 18;
  localparam int PW = W - 2;
  localparam int ML = 4;
  localparam int FD = 1024;

  logic          rdclk = 1'b0;
  logic          reset;
  logic          empty;
  logic          rd;
  logic [W-1:0]  dataout = '0;
  logic          m_valid;
  logic          m_ready;
  logic [PW-1:0] m_data;
  logic          m_sop;
  logic          m_eop;
  logic          m_err;
  logic [15:0]   pkt_count;
  logic [15:0]   err_count;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] fmem [FD];
  int push_cnt = 0;
  int pop_cnt  = 0;

  logic [W:0]   exp_q [$];
  bit           mdl_in_pkt;
  int           mdl_len;
  int           mdl_pkt;
  int           mdl_err;
  int           rd_cnt;
  bit           prev_stall;
  logic [W+1:0] prev_out;
  logic         snap_rd;
  logic         snap_v;

  always #5 rdclk = ~rdclk;

  fifo_rd_deframer #(
    .WIDTH   (W),
    .MAX_LEN (ML)
  ) dut (
    .rdclk     (rdclk),
    .reset     (reset),
    .empty     (empty),
    .rd        (rd),
    .dataout   (dataout),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_sop     (m_sop),
    .m_eop     (m_eop),
    .m_err     (m_err),
    .pkt_count (pkt_count),
    .err_count (err_count)
  );

  // FIFO model: one-cycle read latency, flushed by the shared reset.
  assign empty = (push_cnt == pop_cnt);

  always @(posedge rdclk) begin
    if (reset) begin
      pop_cnt <= push_cnt;
    end else if (rd && !empty) begin
      dataout <= fmem[pop_cnt % FD];
      pop_cnt <= pop_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_word(input logic [W-1:0] w);
    bit sop;
    bit eop;
    bit err;
    sop = w[W-1];
    eop = w[W-2];
    err = 1'b0;
    if (!mdl_in_pkt) begin
      if (!sop) err = 1'b1;
      else if (eop) mdl_pkt++;
      else begin
        mdl_in_pkt = 1'b1;
        mdl_len    = 1;
      end
    end else if (sop) begin
      err        = 1'b1;
      mdl_len    = 1;
      mdl_in_pkt = !eop;
    end else if (mdl_len + 1 > ML) begin
      err        = 1'b1;
      mdl_in_pkt = 1'b0;
    end else if (eop) begin
      mdl_pkt++;
      mdl_in_pkt = 1'b0;
    end else begin
      mdl_len++;
    end
    if (err) mdl_err++;
    if (mdl_pkt > 'hFFFF) mdl_pkt = 'hFFFF;
    if (mdl_err > 'hFFFF) mdl_err = 'hFFFF;
    exp_q.push_back({err, w});
  endtask

  task automatic send(input logic sop, input logic eop,
                      input logic [PW-1:0] pl);
    logic [W-1:0] w;
    w = {sop, eop, pl};
    fmem[push_cnt % FD] = w;
    push_cnt++;
    model_word(w);
  endtask

  task automatic monitor();
    logic [W+1:0] cur;
    cur = {m_valid, m_err, m_sop, m_eop, m_data};
    snap_rd = rd;
    snap_v  = m_valid;
    if (reset) begin
      prev_stall = 1'b0;
      return;
    end
    if (rd) rd_cnt++;
    if (prev_stall) chk("stall_hold", 32'(cur), 32'(prev_out));
    if (m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        chk("spurious_valid", m_valid, 1'b0);
      end else begin
        chk("word", 32'({m_err, m_sop, m_eop, m_data}),
            32'(exp_q.pop_front()));
      end
    end
    prev_stall = m_valid && !m_ready;
    prev_out   = cur;
  endtask

  task automatic tick();
    @(negedge rdclk);
    monitor();
    @(posedge rdclk);
    #1;
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !empty) && n < budget) begin
      tick();
      n++;
    end
    repeat (3) tick();
    chk(tag, exp_q.size(), 0);
    chk({tag, "_pkt"}, pkt_count, mdl_pkt);
    chk({tag, "_err"}, err_count, mdl_err);
  endtask

  initial begin
    int p0;
    int e0;
    int r0;
    reset   = 1'b1;
    m_ready = 1'b0;
    rd_cnt  = 0;
    mdl_in_pkt = 1'b0;
    mdl_len = 0;
    mdl_pkt = 0;
    mdl_err = 0;
    prev_stall = 1'b0;
    prev_out = '0;

    repeat (2) tick();
    chk("rst_rd", rd, 1'b0);
    chk("rst_valid", m_valid, 1'b0);
    chk("rst_data", {m_err, m_sop, m_eop, m_data}, '0);
    chk("rst_pkt", pkt_count, 16'd0);
    chk("rst_err", err_count, 16'd0);
    reset = 1'b0;
    repeat (3) tick();
    chk("idle_rd", snap_rd, 1'b0);

    // Streaming: one 3-word packet, consumer always ready.
    m_ready = 1'b1;
    send(1'b1, 1'b0, 16'h0001);
    send(1'b0, 1'b0, 16'h0002);
    send(1'b0, 1'b1, 16'h0003);
    for (int i = 0; i < 6; i++) begin
      logic [5:0] exp_rd;
      logic [5:0] exp_v;
      exp_rd = 6'b000111;
      exp_v  = 6'b011100;
      tick();
      chk($sformatf("stream_rd%0d", i), snap_rd, exp_rd[i]);
      chk($sformatf("stream_valid%0d", i), snap_v, exp_v[i]);
    end
    drain("stream", 50);
    chk("stream_pkt1", pkt_count, 16'd1);

    // Backpressure: ten single-word packets with no consumer.
    m_ready = 1'b0;
    r0 = rd_cnt;
    for (int i = 0; i < 10; i++)
      send(1'b1, 1'b1, PW'($urandom));
    repeat (8) tick();
    chk("bp_reads", rd_cnt - r0, 3);
    chk("bp_rd_low", snap_rd, 1'b0);
    chk("bp_count", dut.count, 2'd3);
    m_ready = 1'b1;
    tick();
    chk("bp_rd_first", snap_rd, 1'b0);
    tick();
    chk("bp_rd_resume", snap_rd, 1'b1);
    drain("bp", 100);
    chk("bp_pkt11", pkt_count, 16'd11);

    // Framing errors: orphan, then SOP abandoned by SOP|EOP.
    p0 = mdl_pkt;
    e0 = mdl_err;
    send(1'b0, 1'b0, 16'h0005);
    send(1'b1, 1'b0, 16'h0011);
    send(1'b1, 1'b1, 16'h0022);
    drain("frame", 50);
    chk("frame_err2", err_count, 16'(e0 + 2));
    chk("frame_pkt0", pkt_count, 16'(p0));

    // Length limit: SOP plus five plain words with MAX_LEN=4.
    e0 = mdl_err;
    send(1'b1, 1'b0, 16'h0100);
    for (int i = 1; i <= 5; i++)
      send(1'b0, 1'b0, PW'(16'h0100 + i));
    drain("len", 50);
    chk("len_err2", err_count, 16'(e0 + 2));

    // Random traffic with random backpressure and FIFO gaps.
    for (int i = 0; i < 400; i++) begin
      m_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1)
        send($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
             PW'($urandom));
      tick();
    end
    m_ready = 1'b1;
    drain("rand", 2000);

    // Asynchronous reset with two words buffered.
    m_ready = 1'b0;
    send(1'b1, 1'b0, 16'h0AAA);
    send(1'b0, 1'b0, 16'h0BBB);
    repeat (4) tick();
    chk("pre_rst_count", dut.count, 2'd2);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_rd", rd, 1'b0);
    chk("arst_valid", m_valid, 1'b0);
    chk("arst_data", {m_err, m_sop, m_eop, m_data}, '0);
    chk("arst_pkt", pkt_count, 16'd0);
    chk("arst_err", err_count, 16'd0);
    exp_q.delete();
    mdl_in_pkt = 1'b0;
    mdl_len = 0;
    mdl_pkt = 0;
    mdl_err = 0;
    repeat (2) tick();
    reset = 1'b0;
    repeat (3) tick();
    chk("post_rst_rd", snap_rd, 1'b0);
    chk("post_rst_valid", snap_v, 1'b0);

    // Saturation: preload the error counter near its ceiling.
    force dut.err_count = 16'hFFFD;
    tick();
    release dut.err_count;
    mdl_err = 'hFFFD;
    tick();
    chk("sat_preload", err_count, 16'hFFFD);
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++)
      send(1'b0, 1'b0, PW'(i));
    drain("sat", 50);
    chk("sat_hold", err_count, 16'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
